top_module_1: RTL and testbench



---
 rtl/cnn_pkg.sv | 41 ++++
 rtl/top_module_1_pe.sv | 45 ++++
 rtl/top_module_1.sv | 188 ++++++++++++++++++
 tb/tb_top_module_1.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, element types and output helpers for the CNN engine
package cnn_pkg;

  localparam int DATA_SIZE  = 8;
  localparam int ARRAY_SIZE = 9;
  // 8x8 product plus clog2(9)=4 growth bits keeps a full column sum exact
  localparam int PSUM_W     = 2 * DATA_SIZE + $clog2(ARRAY_SIZE);

  typedef logic signed [DATA_SIZE-1:0]   data_t;
  typedef logic signed [2*DATA_SIZE-1:0] prod_t;
  typedef logic signed [PSUM_W-1:0]      psum_t;

  typedef enum logic {
    W_LOAD = 1'b0,
    W_DONE = 1'b1
  } wload_state_t;

  localparam psum_t SAT_MAX = psum_t'(2 ** (DATA_SIZE - 1) - 1);
  localparam psum_t SAT_MIN = psum_t'(-(2 ** (DATA_SIZE - 1)));

  // Clamp a column sum into the signed element range
  function automatic data_t sat_to_data(input psum_t x);
    if (x > SAT_MAX) begin
      return data_t'(SAT_MAX[DATA_SIZE-1:0]);
    end else if (x < SAT_MIN) begin
      return data_t'(SAT_MIN[DATA_SIZE-1:0]);
    end
    return data_t'(x[DATA_SIZE-1:0]);
  endfunction

  // Negative elements become zero, others pass through
  function automatic data_t relu(input data_t x);
    return x[DATA_SIZE-1] ? data_t'(0) : x;
  endfunction

  // Built-in activation buffer contents: act[r][k] = r + k + 1
  function automatic data_t act_default(input int r, input int k);
    return data_t'(r + k + 1);
  endfunction

endpackage

// File: rtl/top_module_1_pe.sv
// rtl/top_module_1_pe.sv - weight-stationary systolic MAC processing element
module systolic_pe
  import cnn_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  enable,
  input  logic  w_load,
  input  data_t w_in,
  input  data_t a_in,
  input  psum_t psum_in,
  output data_t a_out,
  output psum_t psum_out
);

  data_t w_q;
  prod_t prod;

  assign prod = a_in * w_q;

  // Stationary weight: only the full reset or a load strobe changes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else if (w_load) begin
      w_q <= w_in;
    end
  end

  // Activation moves right, partial sum accumulates downward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out    <= '0;
      psum_out <= '0;
    end else if (!clear) begin
      a_out    <= '0;
      psum_out <= '0;
    end else if (enable) begin
      a_out    <= a_in;
      psum_out <= psum_in + psum_t'(prod);
    end
  end

endmodule

// File: rtl/top_module_1.sv
// rtl/top_module_1.sv - CNN convolution engine: activation buffers, weight loader, systolic array
module top_module_1 #(
  parameter int DATA_SIZE  = cnn_pkg::DATA_SIZE,
  parameter int ARRAY_SIZE = cnn_pkg::ARRAY_SIZE,
  parameter int DEPTH      = 16,
  parameter     ACT_INIT_FILE = ""
) (
  input  logic                                     s_clk,
  input  logic                                     reset,
  input  logic                                     s_reset,
  input  logic                                     w_reset,
  input  logic                                     clear,
  input  logic                                     enable,
  input  logic                                     weight_write_enable,
  input  logic [DATA_SIZE*ARRAY_SIZE*ARRAY_SIZE-1:0] weightin,
  input  logic [ARRAY_SIZE-1:0]                    r_en,
  output logic [DATA_SIZE*ARRAY_SIZE-1:0]          macout,
  output logic [DATA_SIZE*ARRAY_SIZE-1:0]          relu_out,
  output logic                                     done,
  output logic                                     w_done
);
  import cnn_pkg::*;

  localparam int PTR_W    = $clog2(DEPTH + 1);
  localparam int DONE_CNT = 2 * ARRAY_SIZE;
  localparam int CNT_W    = $clog2(DONE_CNT + 1);
  localparam int IDX_W    = $clog2(ARRAY_SIZE);

  // Buffer contents are the built-in pattern; a hex image is applied by the
  // memory-initialisation flow outside this RTL.
  localparam unused_act_init_file = ACT_INIT_FILE;

  logic [PTR_W-1:0] ptr   [ARRAY_SIZE];
  data_t            act_q [ARRAY_SIZE];
  data_t            a_link [ARRAY_SIZE][ARRAY_SIZE];
  psum_t            p_link [ARRAY_SIZE][ARRAY_SIZE];
  data_t            mac_col [ARRAY_SIZE];

  logic             pipe_clear_n;
  logic             all_full;
  logic [CNT_W-1:0] done_cnt;

  wload_state_t     w_state, w_state_nxt;
  logic [IDX_W-1:0] w_idx, w_idx_nxt;
  logic [ARRAY_SIZE-1:0] row_load;

  // Stream reset and clear both wipe the array datapath registers
  assign pipe_clear_n = s_reset & clear;

  // Read pointers and the registered buffer output feeding column 0
  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        ptr[r]   <= '0;
        act_q[r] <= '0;
      end
    end else if (!s_reset) begin
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        ptr[r]   <= '0;
        act_q[r] <= '0;
      end
    end else if (!clear) begin
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        act_q[r] <= '0;
      end
    end else if (enable) begin
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        if (r_en[r] && (ptr[r] != PTR_W'(DEPTH))) begin
          act_q[r] <= act_default(r, int'(ptr[r]));
          ptr[r]   <= ptr[r] + 1'b1;
        end else begin
          act_q[r] <= '0;
        end
      end
    end
  end

  // Every row has streamed its whole buffer
  always_comb begin
    all_full = 1'b1;
    for (int r = 0; r < ARRAY_SIZE; r++) begin
      if (ptr[r] != PTR_W'(DEPTH)) begin
        all_full = 1'b0;
      end
    end
  end

  // Drain counter: done after the last data has had time to leave the array
  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      done_cnt <= '0;
      done     <= 1'b0;
    end else if (!s_reset) begin
      done_cnt <= '0;
      done     <= 1'b0;
    end else if (!clear) begin
      done_cnt <= done_cnt;
    end else if (enable && all_full && !done) begin
      done_cnt <= done_cnt + 1'b1;
      if (done_cnt == CNT_W'(DONE_CNT - 1)) begin
        done <= 1'b1;
      end
    end
  end

  // Weight-load sequencer state register
  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      w_state <= W_LOAD;
      w_idx   <= '0;
    end else if (!w_reset) begin
      w_state <= W_LOAD;
      w_idx   <= '0;
    end else begin
      w_state <= w_state_nxt;
      w_idx   <= w_idx_nxt;
    end
  end

  // Weight-load sequencer: one PE row per cycle, then park until w_reset
  always_comb begin
    w_state_nxt = w_state;
    w_idx_nxt   = w_idx;
    row_load    = '0;
    case (w_state)
      W_LOAD: begin
        if (w_reset && weight_write_enable) begin
          row_load[w_idx] = 1'b1;
          if (w_idx == IDX_W'(ARRAY_SIZE - 1)) begin
            w_state_nxt = W_DONE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = w_idx + 1'b1;
          end
        end
      end
      W_DONE: begin
        w_state_nxt = W_DONE;
      end
      default: begin
        w_state_nxt = W_LOAD;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign w_done = (w_state == W_DONE);

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_row
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
      data_t a_src;
      psum_t p_src;

      if (j == 0) begin : g_a_edge
        assign a_src = act_q[i];
      end else begin : g_a_link
        assign a_src = a_link[i][j-1];
      end

      if (i == 0) begin : g_p_edge
        assign p_src = '0;
      end else begin : g_p_link
        assign p_src = p_link[i-1][j];
      end

      systolic_pe u_pe (
        .clk      (s_clk),
        .rst_n    (reset),
        .clear    (pipe_clear_n),
        .enable   (enable),
        .w_load   (row_load[i]),
        .w_in     (data_t'(weightin[DATA_SIZE*(i*ARRAY_SIZE+j) +: DATA_SIZE])),
        .a_in     (a_src),
        .psum_in  (p_src),
        .a_out    (a_link[i][j]),
        .psum_out (p_link[i][j])
      );
    end
  end

  // Outputs are combinational from the bottom row of partial sums
  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_out
    assign mac_col[j]                         = sat_to_data(p_link[ARRAY_SIZE-1][j]);
    assign macout[DATA_SIZE*j +: DATA_SIZE]   = mac_col[j];
    assign relu_out[DATA_SIZE*j +: DATA_SIZE] = relu(mac_col[j]);
  end

endmodule

// File: tb/tb_top_module_1.sv
// tb/tb_top_module_1.sv - self-checking bench for the CNN convolution engine
module tb_top_module_1;

  localparam int DS    = 8;
  localparam int AS    = 9;
  localparam int DEPTH = 16;
  localparam int MAXC  = 64;

  logic                 s_clk = 1'b0;
  logic                 reset, s_reset, w_reset, clear, enable, weight_write_enable;
  logic [DS*AS*AS-1:0]  weightin;
  logic [AS-1:0]        r_en;
  logic [DS*AS-1:0]     macout, relu_out;
  logic                 done, w_done;

  top_module_1 #(
    .DATA_SIZE(DS), .ARRAY_SIZE(AS), .DEPTH(DEPTH), .ACT_INIT_FILE("")
  ) dut (
    .s_clk(s_clk), .reset(reset), .s_reset(s_reset), .w_reset(w_reset),
    .clear(clear), .enable(enable), .weight_write_enable(weight_write_enable),
    .weightin(weightin), .r_en(r_en), .macout(macout), .relu_out(relu_out),
    .done(done), .w_done(w_done)
  );

  always #5 s_clk = ~s_clk;

  typedef struct {
    int               cyc;
    logic [DS*AS-1:0] mac;
    logic [DS*AS-1:0] rel;
    logic             dn;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int fails  = 0;

  int wt [AS][AS];
  logic          p_en [MAXC], p_clr [MAXC], p_srst [MAXC];
  logic [AS-1:0] p_ren [MAXC];
  int            plen;

  int rd_h  [AS][MAXC+1];
  int lastc [MAXC+1];
  int m_ptr [AS];
  int m_cnt;
  bit m_done;

  logic [DS*AS-1:0] cap_mac [MAXC];
  logic [DS*AS-1:0] cap_rel [MAXC];
  logic             cap_done [MAXC];

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic logic [AS-1:0] stair(input int s);
    logic [AS-1:0] v;
    v = '0;
    for (int i = 0; i < AS; i++) if (i <= s) v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_weights(input int mode, input int val);
    for (int i = 0; i < AS; i++)
      for (int j = 0; j < AS; j++) begin
        wt[i][j] = (mode == 0) ? val : (((i * 3 + j * 5) % 7) - 3);
        weightin[DS*(i*AS+j) +: DS] = 8'(wt[i][j]);
      end
  endtask

  task automatic load_weights(input int mode, input int val);
    int cnt;
    set_weights(mode, val);
    @(negedge s_clk);
    w_reset = 1'b0;
    weight_write_enable = 1'b1;
    @(negedge s_clk);
    checks++;
    if (w_done !== 1'b0) begin
      fails++;
      $display("FAIL w_done_clear: got %b, expected 0", w_done);
    end
    w_reset = 1'b1;
    cnt = 0;
    while (w_done !== 1'b1 && cnt < 20) begin
      @(negedge s_clk);
      cnt++;
    end
    checks++;
    if (cnt != AS) begin
      fails++;
      $display("FAIL w_done_latency: got %0d cycles, expected %0d", cnt, AS);
    end
  endtask

  task automatic make_plan(input int len, input int frz_at, input int frz_len, input int clr_at);
    int s;
    s = 0;
    plen = len;
    for (int c = 0; c < len; c++) begin
      p_srst[c] = (c != 0);
      p_clr[c]  = (c != clr_at);
      p_en[c]   = !(c >= frz_at && c < frz_at + frz_len);
      p_ren[c]  = (c == 0) ? '0 : stair(s);
      if (c != 0 && p_en[c] && p_clr[c]) s++;
    end
  endtask

  task automatic run_plan();
    int n, acc, ni, v;
    bit full;
    exp_t e, g;
    n = 0;
    lastc[0] = 0;
    for (int i = 0; i < AS; i++) rd_h[i][0] = 0;
    for (int c = 0; c <= plen; c++) begin
      @(negedge s_clk);
      if (sb.size() > 0) begin
        g = sb.pop_front();
        cap_mac[g.cyc]  = macout;
        cap_rel[g.cyc]  = relu_out;
        cap_done[g.cyc] = done;
        checks += 3;
        if (macout !== g.mac) begin
          fails++;
          $display("FAIL macout c%0d: got %h, expected %h", g.cyc, macout, g.mac);
        end
        if (relu_out !== g.rel) begin
          fails++;
          $display("FAIL relu_out c%0d: got %h, expected %h", g.cyc, relu_out, g.rel);
        end
        if (done !== g.dn) begin
          fails++;
          $display("FAIL done c%0d: got %b, expected %b", g.cyc, done, g.dn);
        end
      end
      if (c < plen) begin
        s_reset = p_srst[c];
        clear   = p_clr[c];
        enable  = p_en[c];
        r_en    = p_ren[c];
        if (!p_srst[c]) begin
          n++;
          lastc[n] = n;
          for (int i = 0; i < AS; i++) begin
            m_ptr[i] = 0;
            rd_h[i][n] = 0;
          end
          m_cnt = 0;
          m_done = 1'b0;
        end else if (!p_clr[c]) begin
          n++;
          lastc[n] = n;
          for (int i = 0; i < AS; i++) rd_h[i][n] = 0;
        end else if (p_en[c]) begin
          full = 1'b1;
          for (int i = 0; i < AS; i++) if (m_ptr[i] < DEPTH) full = 1'b0;
          n++;
          lastc[n] = lastc[n-1];
          for (int i = 0; i < AS; i++) begin
            if (p_ren[c][i] && m_ptr[i] < DEPTH) begin
              rd_h[i][n] = i + m_ptr[i] + 1;
              m_ptr[i]++;
            end else begin
              rd_h[i][n] = 0;
            end
          end
          if (full && !m_done) begin
            m_cnt++;
            if (m_cnt == 2 * AS) m_done = 1'b1;
          end
        end
        e.cyc = c;
        for (int j = 0; j < AS; j++) begin
          acc = 0;
          for (int i = 0; i < AS; i++) begin
            ni = n - j - 1 - (AS - 1 - i);
            if (ni > lastc[n]) acc += rd_h[i][ni] * wt[i][j];
          end
          v = sat8(acc);
          e.mac[DS*j +: DS] = 8'(v);
          e.rel[DS*j +: DS] = (v < 0) ? 8'd0 : 8'(v);
        end
        e.dn = m_done;
        sb.push_back(e);
      end
    end
    enable = 1'b0;
    r_en   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    weightin = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge s_clk);
      checks += 4;
      if (macout !== '0) begin fails++; $display("FAIL reset_macout: got %h, expected 0", macout); end
      if (relu_out !== '0) begin fails++; $display("FAIL reset_relu: got %h, expected 0", relu_out); end
      if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, expected 0", done); end
      if (w_done !== 1'b0) begin fails++; $display("FAIL reset_w_done: got %b, expected 0", w_done); end
    end
  endtask

  task automatic test_weight_load();
    int cnt;
    set_weights(0, 1);
    @(negedge s_clk);
    reset = 1'b1;
    cnt = 0;
    while (w_done !== 1'b1 && cnt < 20) begin
      @(negedge s_clk);
      cnt++;
    end
    checks++;
    if (cnt != AS) begin
      fails++;
      $display("FAIL w_done_after_reset: got %0d cycles, expected %0d", cnt, AS);
    end
    repeat (3) @(negedge s_clk);
    checks++;
    if (w_done !== 1'b1) begin
      fails++;
      $display("FAIL w_done_hold: got %b, expected 1", w_done);
    end
  endtask

  task automatic test_staircase();
    weightin = {AS*AS{8'd5}};
    make_plan(50, -100, 0, -1);
    run_plan();
    checks += 7;
    if (cap_mac[10][7:0] !== 8'd45) begin fails++; $display("FAIL first_col0: got %0d, expected 45", cap_mac[10][7:0]); end
    if (cap_mac[10][15:8] !== 8'd0) begin fails++; $display("FAIL first_col1_early: got %0d, expected 0", cap_mac[10][15:8]); end
    if (cap_mac[11][7:0] !== 8'd54) begin fails++; $display("FAIL second_col0: got %0d, expected 54", cap_mac[11][7:0]); end
    if (cap_mac[11][15:8] !== 8'd45) begin fails++; $display("FAIL first_col1: got %0d, expected 45", cap_mac[11][15:8]); end
    if (cap_mac[18][71:64] !== 8'd45) begin fails++; $display("FAIL first_col8: got %0d, expected 45", cap_mac[18][71:64]); end
    if (cap_done[41] !== 1'b0) begin fails++; $display("FAIL done_early: got %b, expected 0", cap_done[41]); end
    if (cap_done[42] !== 1'b1) begin fails++; $display("FAIL done_rise: got %b, expected 1", cap_done[42]); end
  endtask

  task automatic test_negative_relu();
    load_weights(0, -1);
    make_plan(30, -100, 0, -1);
    run_plan();
    checks += 2;
    if (cap_mac[10][7:0] !== 8'hD3) begin fails++; $display("FAIL neg_col0: got %h, expected d3", cap_mac[10][7:0]); end
    if (cap_rel[10][7:0] !== 8'h00) begin fails++; $display("FAIL neg_relu0: got %h, expected 00", cap_rel[10][7:0]); end
  endtask

  task automatic test_saturation();
    load_weights(0, 127);
    make_plan(30, -100, 0, -1);
    run_plan();
    checks += 2;
    if (cap_mac[10][7:0] !== 8'd127) begin fails++; $display("FAIL sat_pos: got %h, expected 7f", cap_mac[10][7:0]); end
    if (cap_rel[10][7:0] !== 8'd127) begin fails++; $display("FAIL sat_pos_relu: got %h, expected 7f", cap_rel[10][7:0]); end
    load_weights(0, -128);
    make_plan(30, -100, 0, -1);
    run_plan();
    checks += 2;
    if (cap_mac[10][7:0] !== 8'h80) begin fails++; $display("FAIL sat_neg: got %h, expected 80", cap_mac[10][7:0]); end
    if (cap_rel[10][7:0] !== 8'h00) begin fails++; $display("FAIL sat_neg_relu: got %h, expected 00", cap_rel[10][7:0]); end
  endtask

  task automatic test_mixed_weights();
    load_weights(1, 0);
    make_plan(50, -100, 0, -1);
    run_plan();
  endtask

  task automatic test_control();
    load_weights(0, 1);
    make_plan(50, -100, 0, 14);
    run_plan();
    checks++;
    if (cap_mac[14] !== '0) begin fails++; $display("FAIL clear_zero: got %h, expected 0", cap_mac[14]); end
    make_plan(56, 15, 5, -1);
    run_plan();
    checks += 4;
    if (cap_mac[17][7:0] !== 8'd81) begin fails++; $display("FAIL freeze_hold: got %0d, expected 81", cap_mac[17][7:0]); end
    if (cap_mac[20][7:0] !== 8'd90) begin fails++; $display("FAIL freeze_resume: got %0d, expected 90", cap_mac[20][7:0]); end
    if (cap_done[46] !== 1'b0) begin fails++; $display("FAIL freeze_done_early: got %b, expected 0", cap_done[46]); end
    if (cap_done[47] !== 1'b1) begin fails++; $display("FAIL freeze_done_rise: got %b, expected 1", cap_done[47]); end
    make_plan(50, -100, 0, -1);
    run_plan();
    checks += 3;
    if (cap_done[0] !== 1'b0) begin fails++; $display("FAIL sreset_done: got %b, expected 0", cap_done[0]); end
    if (cap_mac[10][7:0] !== 8'd45) begin fails++; $display("FAIL replay_col0: got %0d, expected 45", cap_mac[10][7:0]); end
    if (cap_done[42] !== 1'b1) begin fails++; $display("FAIL replay_done: got %b, expected 1", cap_done[42]); end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    s_reset = 1'b1;
    w_reset = 1'b1;
    clear = 1'b1;
    enable = 1'b1;
    weight_write_enable = 1'b1;
    weightin = '1;
    r_en = '1;
    test_reset();
    enable = 1'b0;
    r_en = '0;
    test_weight_load();
    test_staircase();
    test_negative_relu();
    test_saturation();
    test_mixed_weights();
    test_control();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
